key_array_conditioner: RTL and testbench

- Multi-channel key front end for the board push-buttons (four game direction keys by default).
- Per channel: 2-flop synchroniser, counter-based debounce, press/release edge pulses, a latched toggle state, and optional hold-to-repeat auto-fire.
- Sits between raw FPGA key pins and the game control FSM. One block replaces ad-hoc per-key debounce, edge-detect and hold logic.

---
 rtl/key_array_conditioner.sv | 103 ++++++++++
 tb/tb_key_array_conditioner.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/key_array_conditioner.sv
// key_array_conditioner: per-channel key synchroniser, debounce, edge pulses, toggle and auto-repeat
//
// Ports:
//   clk           system clock
//   reset         asynchronous reset, active low
//   key_in_i      raw key pins (asynchronous), polarity set by ACTIVE_LOW
//   repeat_en_i   per-channel auto-repeat enable
//   toggle_clr_i  per-channel synchronous clear of key_toggle_o
//   key_level_o   debounced level, 1 = pressed
//   key_press_o   one-cycle pulse on debounced press
//   key_release_o one-cycle pulse on debounced release
//   key_event_o   press pulse OR auto-repeat pulse
//   key_toggle_o  flips on every press
module key_array_conditioner #(
    parameter int CHANNELS        = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] key_in_i,
    input  logic [CHANNELS-1:0] repeat_en_i,
    input  logic [CHANNELS-1:0] toggle_clr_i,
    output logic [CHANNELS-1:0] key_level_o,
    output logic [CHANNELS-1:0] key_press_o,
    output logic [CHANNELS-1:0] key_release_o,
    output logic [CHANNELS-1:0] key_event_o,
    output logic [CHANNELS-1:0] key_toggle_o
);
    localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DLY = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PER = CNT_W'(REPEAT_PERIOD);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic             s1_q, s2_q;
        logic             pressed;
        logic [CNT_W-1:0] dcnt_q, dcnt_d, dnext;
        logic [CNT_W-1:0] hcnt_q, hcnt_d, hnext, hlim;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             event_q, event_d;
        logic             toggle_q, toggle_d;
        logic             period_q, period_d;
        logic             holding, fire;

        always_comb begin
            // synchroniser holds raw pin values, so polarity is folded in here
            pressed   = s2_q ^ ACTIVE_LOW;
            dnext     = dcnt_q + 1'b1;
            level_d   = (pressed != level_q && dnext == DEB) ? ~level_q : level_q;
            dcnt_d    = (pressed != level_q && dnext != DEB) ? dnext : '0;
            press_d   = level_d & ~level_q;
            release_d = level_q & ~level_d;
            // a press on the same edge as a clear still lands at 1
            toggle_d  = (toggle_q & ~toggle_clr_i[c]) ^ press_d;
            // hold counter only runs once the key is already registered as pressed,
            // so the press edge itself always leaves hcnt at 0 and never repeats
            holding   = level_q & repeat_en_i[c];
            hlim      = period_q ? PER : DLY;
            hnext     = hcnt_q + 1'b1;
            fire      = holding && hnext == hlim;
            hcnt_d    = (holding && !fire) ? hnext : '0;
            period_d  = holding & (period_q | fire);
            event_d   = press_d | fire;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1_q      <= ACTIVE_LOW;
                s2_q      <= ACTIVE_LOW;
                dcnt_q    <= '0;
                hcnt_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                event_q   <= 1'b0;
                toggle_q  <= 1'b0;
                period_q  <= 1'b0;
            end else begin
                s1_q      <= key_in_i[c];
                s2_q      <= s1_q;
                dcnt_q    <= dcnt_d;
                hcnt_q    <= hcnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                event_q   <= event_d;
                toggle_q  <= toggle_d;
                period_q  <= period_d;
            end
        end

        assign key_level_o[c]   = level_q;
        assign key_press_o[c]   = press_q;
        assign key_release_o[c] = release_q;
        assign key_event_o[c]   = event_q;
        assign key_toggle_o[c]  = toggle_q;
    end
endmodule

// File: tb/tb_key_array_conditioner.sv
// tb_key_array_conditioner: directed and random checks of key_array_conditioner against a window/run-length model
module tb_key_array_conditioner;
    localparam int C   = 4;
    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic [C-1:0] key_in = '1;
    logic [C-1:0] ren    = '0;
    logic [C-1:0] clr    = '0;
    logic [C-1:0] lvl_o, prs_o, rls_o, evt_o, tog_o;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    logic [C-1:0] m_lvl, m_prs, m_rls, m_evt, m_tog;
    int           m_k[C];
    logic [C-1:0] hist[$];

    always #5 clk = ~clk;

    key_array_conditioner #(
        .CHANNELS(C), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .CNT_W(26)
    ) dut (
        .clk(clk), .reset(reset), .key_in_i(key_in), .repeat_en_i(ren),
        .toggle_clr_i(clr), .key_level_o(lvl_o), .key_press_o(prs_o),
        .key_release_o(rls_o), .key_event_o(evt_o), .key_toggle_o(tog_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at t=%0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_lvl = '0; m_prs = '0; m_rls = '0; m_evt = '0; m_tog = '0;
        hist.delete();
        for (int i = 0; i < DEB + 2; i++) hist.push_back('0);
        for (int i = 0; i < C; i++) m_k[i] = 0;
    endfunction

    // hist[0] is the pressed sample taken at this edge; the debounced level
    // flips once the DEB samples hist[2..DEB+1] (the ones that have cleared
    // the two-stage synchroniser) all disagree with the current level.
    // m_k counts consecutive edges on which the key was already down with
    // repeat enabled; repeats fire at DLY, DLY+PER, DLY+2*PER, ...
    function automatic void m_edge(input logic [C-1:0] kin, input logic [C-1:0] en, input logic [C-1:0] cl);
        logic [C-1:0] nl;
        logic         mis, rep;
        hist.push_front(~kin);
        void'(hist.pop_back());
        for (int c = 0; c < C; c++) begin
            mis = 1'b1;
            for (int i = 2; i <= DEB + 1; i++) if (hist[i][c] == m_lvl[c]) mis = 1'b0;
            nl[c]    = mis ? ~m_lvl[c] : m_lvl[c];
            m_k[c]   = (m_lvl[c] && en[c]) ? m_k[c] + 1 : 0;
            rep      = (m_k[c] >= DLY) && ((m_k[c] - DLY) % PER == 0);
            m_prs[c] = nl[c] & ~m_lvl[c];
            m_rls[c] = m_lvl[c] & ~nl[c];
            m_tog[c] = (cl[c] ? 1'b0 : m_tog[c]) ^ m_prs[c];
            m_evt[c] = m_prs[c] | rep;
        end
        m_lvl = nl;
    endfunction

    task automatic step();
        logic [C-1:0] k, e, l;
        k = key_in; e = ren; l = clr;
        @(posedge clk);
        if (!reset) m_reset();
        else m_edge(k, e, l);
        #1;
        chk("level",   lvl_o, m_lvl);
        chk("press",   prs_o, m_prs);
        chk("release", rls_o, m_rls);
        chk("event",   evt_o, m_evt);
        chk("toggle",  tog_o, m_tog);
        chk("press_release_exclusive", prs_o & rls_o, 0);
    endtask

    initial begin
        int ne;
        int rem[C];
        m_reset();
        repeat (2) step();
        reset = 1'b1;
        // key 0 pressed ahead of edge 1: level rises on edge 6
        key_in[0] = 1'b0;
        repeat (5) step();
        chk("k0 level before edge 6", lvl_o[0], 0);
        step();
        chk("k0 level edge 6", lvl_o[0], 1);
        chk("k0 press edge 6", prs_o[0], 1);
        chk("k0 event edge 6", evt_o[0], 1);
        chk("k0 toggle edge 6", tog_o[0], 1);
        step();
        chk("k0 press edge 7", prs_o[0], 0);
        // 3-cycle glitch on key 1
        key_in[1] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 4) key_in[1] = 1'b1;
            step();
            chk("k1 glitch level", lvl_o[1], 0);
            chk("k1 glitch event", evt_o[1], 0);
        end
        // key 2 auto-repeat
        ren[2] = 1'b1;
        key_in[2] = 1'b0;
        for (int i = 0; i < 20 && !prs_o[2]; i++) step();
        chk("k2 press seen", prs_o[2], 1);
        for (int i = 1; i <= 17; i++) begin
            step();
            chk("k2 repeat timing", evt_o[2], (i == 10 || i == 13 || i == 16));
        end
        key_in[2] = 1'b1;
        for (int i = 0; i < 20 && lvl_o[2]; i++) step();
        chk("k2 level fell", lvl_o[2], 0);
        chk("k2 release pulse", rls_o[2], 1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("k2 release one cycle", rls_o[2], 0);
            chk("k2 no repeat after release", evt_o[2], 0);
        end
        ren[2] = 1'b0;
        // key 3 held with repeat disabled, then enabled mid-hold
        key_in[3] = 1'b0;
        ne = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            ne += int'(evt_o[3]);
        end
        chk("k3 single event", ne, 1);
        ren[3] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("k3 re-enable delay", evt_o[3], (i == 10));
        end
        key_in[3] = 1'b1;
        ren[3] = 1'b0;
        repeat (8) step();
        // toggle behaviour on key 0
        key_in[0] = 1'b1;
        repeat (8) step();
        chk("k0 released", lvl_o[0], 0);
        chk("k0 toggle held", tog_o[0], 1);
        key_in[0] = 1'b0;
        repeat (6) step();
        chk("k0 second press", prs_o[0], 1);
        chk("k0 toggle back to 0", tog_o[0], 0);
        key_in[0] = 1'b1;
        repeat (8) step();
        key_in[0] = 1'b0;
        repeat (5) step();
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        chk("k0 third press", prs_o[0], 1);
        chk("k0 press beats clear", tog_o[0], 1);
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        chk("k0 clear", tog_o[0], 0);
        // reset while key 0 is held and repeating
        ren[0] = 1'b1;
        repeat (15) step();
        reset = 1'b0;
        #1;
        chk("async reset level", lvl_o, 0);
        chk("async reset event", evt_o, 0);
        chk("async reset toggle", tog_o, 0);
        m_reset();
        repeat (2) step();
        reset = 1'b1;
        repeat (5) step();
        chk("post-reset press early", prs_o[0], 0);
        step();
        chk("post-reset press edge 6", prs_o[0], 1);
        // random traffic on all channels
        for (int i = 0; i < C; i++) rem[i] = 0;
        repeat (1500) begin
            for (int c = 0; c < C; c++) begin
                if (rem[c] == 0) begin
                    key_in[c] = ~key_in[c];
                    rem[c] = $urandom_range(1, 30);
                end else rem[c]--;
            end
            if ($urandom_range(0, 29) == 0) ren[$urandom_range(0, C - 1)] ^= 1'b1;
            clr = ($urandom_range(0, 15) == 0) ? C'($urandom) : '0;
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
